segment_write_arbiter: RTL
==========================

// Module: segment_write_arbiter
//
// PURPOSE
//   Shares the single segment-register-file write port between two requesters:
//   port A (writeback stage) and port B (far-transfer / microcode sequencer).
//   Each port gets a one-entry hold buffer; a round-robin arbiter grants one write per cycle.
//   The granted write drives the register file and the segment stall tracker's
//   decrement inputs (write_select/write_enable), so pending-access counts retire exactly once.
//
// PARAMETERS
//   DATA_WIDTH  16  segment selector width written to the register file
//   SEL_WIDTH   3   segment select width (ES=0,CS=1,SS=2,DS=3,FS=4,GS=5)
//   NUM_SEGS    6   number of legal selects; sel >= NUM_SEGS is illegal
//
// PORTS
//   clk           in   1           clock
//   reset         in   1           synchronous, active-high reset
//   a_valid       in   1           port A request valid
//   a_ready       out  1           port A may transfer this cycle
//   a_sel         in   SEL_WIDTH   port A target segment
//   a_data        in   DATA_WIDTH  port A selector value
//   b_valid       in   1           port B request valid
//   b_ready       out  1           port B may transfer this cycle
//   b_sel         in   SEL_WIDTH   port B target segment
//   b_data        in   DATA_WIDTH  port B selector value
//   seg_we        out  1           register-file write enable (one-cycle pulse per write)
//   seg_wsel      out  SEL_WIDTH   register-file write select
//   seg_wdata     out  DATA_WIDTH  register-file write data
//   write_enable  out  1           to stall tracker; identical to seg_we
//   write_select  out  SEL_WIDTH   to stall tracker; identical to seg_wsel
//   err_bad_sel   out  1           one-cycle pulse: an illegal sel was accepted and dropped
//
// BEHAVIOUR
//   - Reset: both hold buffers empty, rr_ptr=A, seg_we=0, seg_wsel=0, seg_wdata=0,
//     write_enable=0, write_select=0, err_bad_sel=0. Reset wins over every other event;
//     buffered entries are discarded (tracker is reset by the same signal).
//   - Handshake: transfer on X_valid & X_ready at rising edge. X_ready = buffer X empty OR
//     buffer X granted this cycle (full throughput, no bubble). X_ready has no combinational
//     path from X_valid. Producer holds sel/data stable while valid & !ready.
//   - Arbitration (combinational on buffer-full flags): only A full -> grant A; only B full ->
//     grant B; both full -> grant port named by rr_ptr, then rr_ptr flips to the other port.
//     rr_ptr changes only on a contended grant.
//   - Output: granted entry loaded into seg_wsel/seg_wdata with seg_we=1 on the next edge;
//     seg_we otherwise 0. Latency accept-edge N -> seg_we high in cycle N+2. Max one write/cycle.
//   - Illegal sel (>= NUM_SEGS): entry still buffered and granted normally (keeps ordering),
//     but seg_we/write_enable stay 0 and err_bad_sel pulses 1 in the would-be write cycle.
//   - Same-segment writes from A and B: both performed in grant order; no merging.
//   - Per-port ordering preserved (single-entry buffer); no cross-port ordering guarantee.
//   - Starvation bound: a full buffer is granted within 2 cycles.
//
// STRUCTURE
//   - Shared package: segment encodings (SEG_ES..SEG_GS), NUM_SEGS, SEL_WIDTH, DATA_WIDTH.
//   - Sub-module seg_wr_hold_buffer (instantiated twice): one-entry valid/ready buffer with
//     full flag, sel/data registers, take-on-grant pop; built from the register/mux library.
//   - Top: two buffers, round-robin grant logic + rr_ptr flop, legality compare, output flops.
//
// TESTING
//   1. Reset held 3 cycles with a_valid=b_valid=1 -> all outputs 0, a_ready=b_ready=1 after release.
//   2. A only: a_sel=3,a_data=16'h0023 accepted edge N -> seg_we=1,seg_wsel=3,seg_wdata=0023 in N+2, one cycle.
//   3. A and B valid same cycle (A: sel 1/16'h0008, B: sel 2/16'h0010), held 4 transfers each -> writes
//      alternate A,B,A,B...; a_ready/b_ready each high every other cycle; write_enable mirrors seg_we.
//   4. A streams 8 writes back-to-back, B idle -> 8 consecutive seg_we pulses, a_ready never drops.
//   5. b_sel=7 accepted -> err_bad_sel=1 for one cycle, seg_we=0, write_enable=0; next legal write proceeds.
//   6. Reset asserted while both buffers full -> no write emitted after reset; buffers empty, rr_ptr=A.

Source files
------------

// File: rtl/segment_write_arbiter_pkg.sv
// segment_write_arbiter_pkg: segment encodings, widths and port ids shared by the write arbiter
package segment_write_arbiter_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int SEL_WIDTH  = 3;
    localparam int NUM_SEGS   = 6;
    typedef enum logic [SEL_WIDTH-1:0] {
        SEG_ES = 3'd0,
        SEG_CS = 3'd1,
        SEG_SS = 3'd2,
        SEG_DS = 3'd3,
        SEG_FS = 3'd4,
        SEG_GS = 3'd5
    } seg_e;
    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;
endpackage

// File: rtl/segment_write_arbiter_hold_buffer.sv
// seg_wr_hold_buffer: one-entry valid/ready hold buffer, popped when the arbiter grants it
module seg_wr_hold_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_WIDTH-1:0]  in_sel,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  take,
    output logic                  full,
    output logic [SEL_WIDTH-1:0]  sel,
    output logic [DATA_WIDTH-1:0] data
);
    assign in_ready = !full || take;
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            sel  <= '0;
            data <= '0;
        end else if (in_valid && in_ready) begin
            full <= 1'b1;
            sel  <= in_sel;
            data <= in_data;
        end else if (take) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/segment_write_arbiter.sv
// segment_write_arbiter: round-robin sharing of the segment register-file write port between two requesters
module segment_write_arbiter #(
    parameter int DATA_WIDTH = segment_write_arbiter_pkg::DATA_WIDTH,
    parameter int SEL_WIDTH  = segment_write_arbiter_pkg::SEL_WIDTH,
    parameter int NUM_SEGS   = segment_write_arbiter_pkg::NUM_SEGS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [SEL_WIDTH-1:0]  a_sel,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [SEL_WIDTH-1:0]  b_sel,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  seg_we,
    output logic [SEL_WIDTH-1:0]  seg_wsel,
    output logic [DATA_WIDTH-1:0] seg_wdata,
    output logic                  write_enable,
    output logic [SEL_WIDTH-1:0]  write_select,
    output logic                  err_bad_sel
);
    import segment_write_arbiter_pkg::*;
    logic                  a_full, b_full, a_take, b_take, g_any, g_legal;
    logic [SEL_WIDTH-1:0]  a_held_sel, b_held_sel, g_sel;
    logic [DATA_WIDTH-1:0] a_held_data, b_held_data, g_data;
    port_e                 rr_ptr;
    seg_wr_hold_buffer #(.DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_buf_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
        .in_sel(a_sel), .in_data(a_data), .take(a_take),
        .full(a_full), .sel(a_held_sel), .data(a_held_data)
    );
    seg_wr_hold_buffer #(.DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_buf_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
        .in_sel(b_sel), .in_data(b_data), .take(b_take),
        .full(b_full), .sel(b_held_sel), .data(b_held_data)
    );
    assign a_take  = a_full && (!b_full || rr_ptr == PORT_A);
    assign b_take  = b_full && !a_take;
    assign g_any   = a_take || b_take;
    assign g_sel   = a_take ? a_held_sel : b_held_sel;
    assign g_data  = a_take ? a_held_data : b_held_data;
    // Extra bit keeps the compare correct even when NUM_SEGS == 2**SEL_WIDTH
    assign g_legal = {1'b0, g_sel} < (SEL_WIDTH + 1)'(NUM_SEGS);
    assign write_enable = seg_we;
    assign write_select = seg_wsel;
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= PORT_A;
            seg_we      <= 1'b0;
            seg_wsel    <= '0;
            seg_wdata   <= '0;
            err_bad_sel <= 1'b0;
        end else begin
            if (a_full && b_full)
                rr_ptr <= a_take ? PORT_B : PORT_A;
            seg_we      <= g_any && g_legal;
            err_bad_sel <= g_any && !g_legal;
            if (g_any && g_legal) begin
                seg_wsel  <= g_sel;
                seg_wdata <= g_data;
            end
        end
    end
endmodule
